iomem_sevenseg: RTL and testbench
=================================

// Module: iomem_sevenseg
// PURPOSE
//  Memory-mapped 4-digit seven-segment scanner on the picosoc iomem bus (Basys3).
//  Software writes four hex nibbles plus control bits. The block time-multiplexes the
//  digits onto the active-low seg/dp/an pins, with hex decode and an anti-ghosting guard.
//  It sits downstream of the SoC iomem port, beside the GPIO slave, and replaces direct
//  GPIO driving of seg/an.
// PARAMETERS
//  BASE_ADDR     8'h04        iomem_addr[31:24] decode value
//  CLK_HZ        100000000    clk frequency
//  REFRESH_HZ    1000         full 4-digit refresh rate; DIGIT_CYCLES = CLK_HZ/(4*REFRESH_HZ), must be >=32
//  GUARD_CYCLES  64           all-anodes-off cycles at the start of each digit slot; must be < DIGIT_CYCLES
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  iomem_valid  in   1   bus request
//  iomem_ready  out  1   one-cycle acknowledge
//  iomem_wstrb  in   4   byte write strobes; 0 = read
//  iomem_addr   in   32  byte address
//  iomem_wdata  in   32  write data
//  iomem_rdata  out  32  read data, valid while iomem_ready=1
//  seg          out  7   segments a..g = [0]..[6], active-low
//  dp           out  1   decimal point, active-low
//  an           out  4   digit anodes, active-low; an[0] = rightmost digit
// BEHAVIOUR
//  Reset: iomem_ready=0, iomem_rdata=0, seg=7'h7F, dp=1, an=4'hF, all registers 0, digit index 0, counters 0.
//  Bus handshake:
//   - Select when iomem_valid && !iomem_ready && addr[31:24]==BASE_ADDR.
//   - iomem_ready=1 exactly one cycle after select, then 0 for at least one cycle.
//   - No response when the address does not match.
//   - Writes honour each wstrb byte independently.
//   - rdata is registered with ready and carries the pre-write value.
//  Register map, addr[3:2]:
//   0 DATA   [15:0] nibbles, digit i = DATA[4i+3:4i]; [31:16] read 0
//   1 CTRL   [3:0] blank mask (1 = digit dark); [7:4] dp per digit; [8] enable; rest 0
//   2 STATUS read-only: [1:0] current digit index, [31:16] slot phase count[15:0]; writes ignored
//   3 BRIGHT see CONFIGURATION
//  Scanner:
//   - phase counter runs 0..DIGIT_CYCLES-1, then wraps.
//   - On wrap, digit index increments mod 4 (3 -> 0).
//   - Scanning runs regardless of enable.
//  Outputs:
//   - Registered, 1-cycle latency from counter/register state.
//   - an[i]=0 only when i==index && enable && !blank[i] && phase>=GUARD_CYCLES (&& PWM on).
//   - seg = ~hex7(DATA nibble[index]); dp = ~CTRL[4+index].
//   - When the anode is off, seg=7'h7F and dp=1.
//  Mid-slot writes:
//   - DATA/CTRL writes take effect on the next cycle's output; no slot restart.
//   - Clearing enable darkens all anodes on the next output update.
//  Reset asserted mid-slot or mid-transaction: all state returns to reset values next cycle; no ready pulse.
// CONFIGURATION
//  SEVENSEG_DIM_EN defined:
//   - BRIGHT[3:0] is a RW register.
//   - After the guard, the slot splits into 16 sub-slices of (DIGIT_CYCLES-GUARD_CYCLES)/16 cycles.
//   - Anode is on for sub-slices 0..BRIGHT; BRIGHT=15 gives full on.
//   - Reset value is 4'hF.
//  SEVENSEG_DIM_EN undefined: BRIGHT reads 0, writes are ignored, digits always full brightness.
// STRUCTURE
//  Package sevenseg_pkg:
//   - register offset constants REG_DATA/REG_CTRL/REG_STATUS/REG_BRIGHT
//   - CTRL bit-position localparams
//   - the 16-entry hex-to-segment constant table
//  Sub-module sevenseg_hex_decode: 4-bit nibble in, 7-bit active-high segments out; combinational, used once.
//  Top holds the bus slave, registers, scan/PWM counters and output registers.
// TESTING  (CLK_HZ=1600, REFRESH_HZ=4 -> DIGIT_CYCLES=100, GUARD_CYCLES=4)
//  1 Reset, then read CTRL/DATA -> ready for exactly 1 cycle, rdata 0; an=F, seg=7F throughout.
//  2 Write DATA=0x1234, CTRL=0x100 -> slot 0: an=E, seg=~hex7(4)=7'h19 from phase 4; slot 1 shows 3, wrap 3->0 after 400 cycles.
//  3 Write byte strobe wstrb=4'b0010 with wdata 0x0000AB00 over DATA 0x1234 -> DATA=0xAB34; read returns 0x1234 then 0xAB34.
//  4 CTRL=0x1A5 (blank 5, dp A) -> digits 0,2 dark (an=F); digit 1 shows dp=0; digit 3 dp=0; guard cycles an=F.
//  5 Access with addr[31:24]=0x03 -> no ready; wdata not captured. Back-to-back valid -> ready pulses separated by a low cycle.
//  6 DIM_EN: BRIGHT=3 -> an low for exactly 4*6=24 cycles per slot (sub-slice 6 cycles); undefined -> BRIGHT reads 0, an low 96 cycles.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg: shared constants for the iomem seven-segment scanner.
//   - Register offsets, decoded from iomem_addr[3:2]
//   - CTRL register bit positions
//   - Hex-to-segment table, active-high, segments a..g = bits [0]..[6]
// Optional feature macro used by the top: SEVENSEG_DIM_EN (PWM brightness).
package sevenseg_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_BRIGHT = 2'd3;

  localparam int CTRL_BLANK_LSB = 0;
  localparam int CTRL_DP_LSB    = 4;
  localparam int CTRL_EN_BIT    = 8;

  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sevenseg_hex_decode.sv
// sevenseg_hex_decode: combinational hex digit to seven-segment pattern.
// Ports:
//   nibble    in  4  hex digit 0..F
//   segments  out 7  active-high segments, a..g = [0]..[6]
module sevenseg_hex_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = HEX7_TABLE[nibble];

endmodule

// File: rtl/iomem_sevenseg.sv
// iomem_sevenseg: memory-mapped 4-digit seven-segment scanner on the picosoc
// iomem bus. Software writes four hex nibbles plus control bits; the block
// time-multiplexes the digits onto active-low seg/dp/an with a guard interval
// (all anodes off) at the start of each digit slot to avoid ghosting.
// Build option: define SEVENSEG_DIM_EN to make BRIGHT a RW register that
// gates the anode with a 16-step PWM after the guard; otherwise BRIGHT reads 0.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   iomem_valid/ready    request / one-cycle acknowledge
//   iomem_wstrb          byte write strobes (0 = read)
//   iomem_addr/wdata     byte address, write data
//   iomem_rdata          read data, valid while iomem_ready=1 (pre-write value)
//   seg, dp, an          active-low segments, decimal point, anodes (an[0] rightmost)
module iomem_sevenseg
  import sevenseg_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR    = 8'h04,
  parameter int unsigned CLK_HZ       = 100000000,
  parameter int unsigned REFRESH_HZ   = 1000,
  parameter int unsigned GUARD_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int unsigned DIGIT_CYCLES = CLK_HZ / (4 * REFRESH_HZ);
  localparam int unsigned SUB_CYCLES   = (DIGIT_CYCLES - GUARD_CYCLES) / 16;

  logic [15:0] data_q;
  logic [8:0]  ctrl_q;
  logic [3:0]  bright_q;
  logic [31:0] phase_q;
  logic [1:0]  idx_q;

  logic        sel;
  logic        wr;
  logic [31:0] rd_mux;

  // A request is taken only while ready is low, which forces the idle
  // cycle between back-to-back acknowledges.
  assign sel = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
  assign wr  = sel && (iomem_wstrb != 4'b0000);

  always_comb begin
    rd_mux = 32'd0;
    case (iomem_addr[3:2])
      REG_DATA:   rd_mux = {16'd0, data_q};
      REG_CTRL:   rd_mux = {23'd0, ctrl_q};
      REG_STATUS: rd_mux = {phase_q[15:0], 14'd0, idx_q};
      REG_BRIGHT: rd_mux = {28'd0, bright_q};
      default:    rd_mux = 32'd0;
    endcase
  end

  // Bus slave and software-visible registers
  always_ff @(posedge clk) begin
    if (reset) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= 32'd0;
      data_q      <= 16'd0;
      ctrl_q      <= 9'd0;
    end else begin
      iomem_ready <= sel;
      iomem_rdata <= sel ? rd_mux : 32'd0;
      if (wr && iomem_addr[3:2] == REG_DATA) begin
        if (iomem_wstrb[0]) data_q[7:0]  <= iomem_wdata[7:0];
        if (iomem_wstrb[1]) data_q[15:8] <= iomem_wdata[15:8];
      end
      if (wr && iomem_addr[3:2] == REG_CTRL) begin
        if (iomem_wstrb[0]) ctrl_q[7:0] <= iomem_wdata[7:0];
        if (iomem_wstrb[1]) ctrl_q[8]   <= iomem_wdata[8];
      end
    end
  end

`ifdef SEVENSEG_DIM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      bright_q <= 4'hF;
    end else if (wr && iomem_addr[3:2] == REG_BRIGHT && iomem_wstrb[0]) begin
      bright_q <= iomem_wdata[3:0];
    end
  end
`else
  assign bright_q = 4'h0;
`endif

  // Scan counters: phase within a digit slot, digit index wraps 3 -> 0
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 32'd0;
      idx_q   <= 2'd0;
    end else if (phase_q == DIGIT_CYCLES - 1) begin
      phase_q <= 32'd0;
      idx_q   <= idx_q + 2'd1;
    end else begin
      phase_q <= phase_q + 32'd1;
    end
  end

  logic [3:0]  blank_mask;
  logic [3:0]  dp_mask;
  logic        guard_done;
  logic        pwm_on;
  logic        lit;
  logic [3:0]  nibble;
  logic [6:0]  seg_on;

  assign blank_mask = ctrl_q[CTRL_BLANK_LSB +: 4];
  assign dp_mask    = ctrl_q[CTRL_DP_LSB +: 4];
  assign guard_done = (phase_q >= GUARD_CYCLES);

`ifdef SEVENSEG_DIM_EN
  logic [31:0] lit_cycles;
  // Sub-slices 0..BRIGHT are lit; 15 is forced full-on so a non-divisible
  // slot remainder never leaves a dark tail at maximum brightness.
  assign lit_cycles = ({28'd0, bright_q} + 32'd1) * SUB_CYCLES;
  assign pwm_on     = (bright_q == 4'hF) || ((phase_q - GUARD_CYCLES) < lit_cycles);
`else
  assign pwm_on = 1'b1;
`endif

  assign lit    = ctrl_q[CTRL_EN_BIT] && !blank_mask[idx_q] && guard_done && pwm_on;
  assign nibble = data_q[{idx_q, 2'b00} +: 4];

  sevenseg_hex_decode u_hex (
    .nibble   (nibble),
    .segments (seg_on)
  );

  // Output registers: one cycle behind counter/register state
  always_ff @(posedge clk) begin
    if (reset) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else if (lit) begin
      seg <= ~seg_on;
      dp  <= ~dp_mask[idx_q];
      an  <= ~(4'b0001 << idx_q);
    end else begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:16],
                         iomem_wstrb[3:2], SUB_CYCLES[0]};

endmodule

// File: tb/tb_iomem_sevenseg.sv
// tb_iomem_sevenseg: directed self-checking bench for iomem_sevenseg with
// CLK_HZ=1600, REFRESH_HZ=4 (100-cycle digit slots), GUARD_CYCLES=4.
module tb_iomem_sevenseg;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_checks = 0;
  int n_pass   = 0;

  int cnt_an [16];
  int bad_out;

  iomem_sevenseg #(
    .BASE_ADDR    (8'h04),
    .CLK_HZ       (1600),
    .REFRESH_HZ   (4),
    .GUARD_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .seg         (seg),
    .dp          (dp),
    .an          (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  function automatic logic [31:0] reg_addr(input logic [7:0] base, input logic [1:0] off);
    return {base, 20'd0, off, 2'b00};
  endfunction

  task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wd, output logic [31:0] rd, output logic ok);
    ok = 1'b0;
    rd = 32'hDEAD_BEEF;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wstrb = strb;
    iomem_wdata = wd;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (iomem_ready) begin
        ok = 1'b1;
        rd = iomem_rdata;
        break;
      end
    end
    @(negedge clk);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
  endtask

  // Samples n cycles of outputs; tallies anode patterns and counts samples
  // whose seg/dp disagree with what the given DATA/CTRL should display.
  task automatic scan(input int n, input logic [15:0] d, input logic [8:0] c);
    for (int i = 0; i < 16; i++) cnt_an[i] = 0;
    bad_out = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cnt_an[an]++;
      if (an == 4'hF) begin
        if (seg !== 7'h7F || dp !== 1'b1) bad_out++;
      end else begin
        int di;
        di = -1;
        for (int j = 0; j < 4; j++) if (an == ~(4'b0001 << j)) di = j;
        if (di < 0) bad_out++;
        else if (seg !== ~hex7(d[4*di +: 4]) || dp !== ~c[4+di]) bad_out++;
      end
    end
  endtask

  logic [31:0] rd;
  logic        ok;
  logic [31:0] st [4];
  logic [3:0]  pat;

  initial begin
    reset       = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'b0000;
    iomem_addr  = 32'd0;
    iomem_wdata = 32'd0;

    // 1: reset state and reads of zeroed registers
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_an",    {28'd0, an}, 32'hF);
    check("rst_seg",   {25'd0, seg}, 32'h7F);
    check("rst_dp",    {31'd0, dp}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus(reg_addr(8'h04, 2'd1), 4'h0, 32'd0, rd, ok);
    check("rd_ctrl_ack", {31'd0, ok}, 32'd1);
    check("rd_ctrl", rd, 32'd0);
    @(posedge clk);
    #1;
    check("ready_one_cycle", {31'd0, iomem_ready}, 32'd0);
    bus(reg_addr(8'h04, 2'd0), 4'h0, 32'd0, rd, ok);
    check("rd_data", rd, 32'd0);
`ifdef SEVENSEG_DIM_EN
    bus(reg_addr(8'h04, 2'd3), 4'h0, 32'd0, rd, ok);
    check("rd_bright_rst", rd, 32'hF);
`endif
    scan(50, 16'h0000, 9'h000);
    check("rst_dark", cnt_an[15], 32'd50);
    check("rst_dark_seg", bad_out, 32'd0);

    // 2: basic display and digit scanning
    bus(reg_addr(8'h04, 2'd0), 4'hF, 32'h0000_1234, rd, ok);
    bus(reg_addr(8'h04, 2'd1), 4'hF, 32'h0000_0100, rd, ok);
    scan(400, 16'h1234, 9'h100);
    check("scan_an0", cnt_an[4'hE], 32'd96);
    check("scan_an1", cnt_an[4'hD], 32'd96);
    check("scan_an2", cnt_an[4'hB], 32'd96);
    check("scan_an3", cnt_an[4'h7], 32'd96);
    check("scan_guard", cnt_an[4'hF], 32'd16);
    check("scan_seg", bad_out, 32'd0);
    for (int k = 0; k < 4; k++) begin
      bus(reg_addr(8'h04, 2'd2), 4'h0, 32'd0, st[k], ok);
      if (k < 3) repeat (98) @(negedge clk);
    end
    check("status_low0", {18'd0, st[0][15:2]}, 32'd0);
    for (int k = 1; k < 4; k++) begin
      check("status_phase", {16'd0, st[k][31:16]}, {16'd0, st[0][31:16]});
      check("status_index", {30'd0, st[k][1:0]}, {30'd0, st[0][1:0] + 2'(k)});
    end

    // 3: byte strobes; rdata carries the pre-write value
    bus(reg_addr(8'h04, 2'd0), 4'b0010, 32'h0000_AB00, rd, ok);
    check("wstrb_prewrite", rd, 32'h0000_1234);
    bus(reg_addr(8'h04, 2'd0), 4'h0, 32'd0, rd, ok);
    check("wstrb_data", rd, 32'h0000_AB34);

    // 4: blank mask and decimal points
    bus(reg_addr(8'h04, 2'd1), 4'hF, 32'h0000_01A5, rd, ok);
    bus(reg_addr(8'h04, 2'd1), 4'h0, 32'd0, rd, ok);
    check("ctrl_rd", rd, 32'h0000_01A5);
    scan(400, 16'hAB34, 9'h1A5);
    check("blank_an0", cnt_an[4'hE], 32'd0);
    check("blank_an1", cnt_an[4'hD], 32'd96);
    check("blank_an2", cnt_an[4'hB], 32'd0);
    check("blank_an3", cnt_an[4'h7], 32'd96);
    check("blank_dark", cnt_an[4'hF], 32'd208);
    check("blank_seg_dp", bad_out, 32'd0);

    // clearing enable darkens everything
    bus(reg_addr(8'h04, 2'd1), 4'hF, 32'h0000_00A5, rd, ok);
    scan(400, 16'hAB34, 9'h0A5);
    check("disable_dark", cnt_an[4'hF], 32'd400);

    // 5: address mismatch and back-to-back requests
    bus(reg_addr(8'h03, 2'd0), 4'hF, 32'h0000_FFFF, rd, ok);
    check("miss_no_ready", {31'd0, ok}, 32'd0);
    bus(reg_addr(8'h04, 2'd0), 4'h0, 32'd0, rd, ok);
    check("miss_no_write", rd, 32'h0000_AB34);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = reg_addr(8'h04, 2'd0);
    iomem_wstrb = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      pat[k] = iomem_ready;
    end
    @(negedge clk);
    iomem_valid = 1'b0;
    check("b2b_ready", {28'd0, pat}, 32'h5);

    // reset in the middle of a transaction: no acknowledge, state cleared
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = reg_addr(8'h04, 2'd0);
    reset       = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", {31'd0, iomem_ready}, 32'd0);
    check("midrst_an", {28'd0, an}, 32'hF);
    @(negedge clk);
    iomem_valid = 1'b0;
    reset       = 1'b0;
    bus(reg_addr(8'h04, 2'd0), 4'h0, 32'd0, rd, ok);
    check("midrst_data", rd, 32'd0);

    // 6: brightness
    bus(reg_addr(8'h04, 2'd0), 4'hF, 32'h0000_1234, rd, ok);
    bus(reg_addr(8'h04, 2'd1), 4'hF, 32'h0000_0100, rd, ok);
    bus(reg_addr(8'h04, 2'd3), 4'hF, 32'h0000_0003, rd, ok);
    bus(reg_addr(8'h04, 2'd3), 4'h0, 32'd0, rd, ok);
    scan(400, 16'h1234, 9'h100);
`ifdef SEVENSEG_DIM_EN
    check("bright_rd", rd, 32'd3);
    check("dim_an0", cnt_an[4'hE], 32'd24);
    check("dim_an3", cnt_an[4'h7], 32'd24);
    check("dim_dark", cnt_an[4'hF], 32'd304);
`else
    check("bright_rd", rd, 32'd0);
    check("full_an0", cnt_an[4'hE], 32'd96);
    check("full_an3", cnt_an[4'h7], 32'd96);
    check("full_dark", cnt_an[4'hF], 32'd16);
`endif
    check("bright_seg", bad_out, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
